// File: rtl/scalar_arx_decryptor_if.sv
// Valid/ready bundle for the scalar ARX decryptor.
// Master drives ciphertext and key in, slave returns plaintext and flags.
interface scalar_arx_decryptor_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] cipher_in;
  logic [N-1:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] plain_out;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, cipher_in, key_in, out_ready,
    input  in_ready, out_valid, plain_out, out_flags
  );

  modport slave (
    input  in_valid, cipher_in, key_in, out_ready,
    output in_ready, out_valid, plain_out, out_flags
  );
endinterface

// File: rtl/scalar_arx_decryptor.sv
// Iterative ARX decryptor: one inverse round per clock.
// Optional ARX_DEC_ABORT_EN adds an abort input that drops the word in flight.
module scalar_arx_decryptor #(
  parameter int N      = 32,
  parameter int ROUNDS = 8,
  parameter int ROT    = 7
) (
  input logic clk,
  input logic rst_n,
`ifdef ARX_DEC_ABORT_EN
  input logic abort,
`endif
  scalar_arx_decryptor_if.slave bus
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  x_reg;
  logic [N-1:0]  key_reg;
  logic [3:0]    flags_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [N-1:0]  rk;
  logic [N-1:0]  diff;
  logic [N-1:0]  nxt;
  logic          carry;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v);
    if (ROT == 0) return v;
    return (v << ROT) | (v >> (N - ROT));
  endfunction

  always_comb begin
    rk    = key_reg + N'(cnt);
    diff  = x_reg - rk;
    nxt   = rol(diff) ^ rk;
    carry = (x_reg >= rk);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      x_reg       <= '0;
      key_reg     <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg      <= bus.cipher_in;
            key_reg    <= bus.key_in;
            cnt        <= CW'(ROUNDS - 1);
            state      <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          x_reg <= nxt;
          // last round uses rk_0 = key, so carry is the final borrow
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            flags_q     <= {nxt[N-1], (nxt == '0), 1'b0, carry};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
`ifdef ARX_DEC_ABORT_EN
      if (abort && state != IDLE) begin
        state       <= IDLE;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.plain_out = x_reg;
  assign bus.out_flags = flags_q;

endmodule

// File: tb/tb_scalar_arx_decryptor.sv
// Scoreboard bench: a 1-round instance with hand vectors and a
// default instance fed by an encryption reference model.
module tb_scalar_arx_decryptor;
  localparam int N   = 32;
  localparam int R   = 8;
  localparam int ROT = 7;

  typedef struct packed {
    logic [N-1:0] p;
    logic [3:0]   f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scalar_arx_decryptor_if #(.N(N)) ia ();
  scalar_arx_decryptor_if #(.N(N)) ib ();

`ifdef ARX_DEC_ABORT_EN
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;
`endif

  scalar_arx_decryptor #(.N(N), .ROUNDS(1), .ROT(ROT)) dut_a (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ARX_DEC_ABORT_EN
    .abort(abort_a),
`endif
    .bus(ia)
  );

  scalar_arx_decryptor #(.N(N), .ROUNDS(R), .ROT(ROT)) dut_b (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ARX_DEC_ABORT_EN
    .abort(abort_b),
`endif
    .bus(ib)
  );

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_a = 0;
  int acc_b = 0;
  logic ova_d = 1'b0;
  logic ovb_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ror(input logic [N-1:0] v);
    if (ROT == 0) return v;
    return (v >> ROT) | (v << (N - ROT));
  endfunction

  function automatic exp_t enc(input logic [N-1:0] p, input logic [N-1:0] k,
                               output logic [N-1:0] c);
    logic [N-1:0] x, x1, rk;
    x  = p;
    x1 = '0;
    for (int i = 0; i < R; i++) begin
      rk = k + N'(i);
      x  = ror(x ^ rk) + rk;
      if (i == 0) x1 = x;
    end
    c = x;
    return '{p: p, f: {p[N-1], (p == '0), 1'b0, (x1 >= k)}};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ia.in_valid && ia.in_ready) acc_a = cyc + 1;
      if (ia.out_valid && !ova_d) chk("lat_a", 64'(cyc - acc_a), 64'(1));
      if (ia.out_valid && ia.out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_a_unexpected act=%h exp=none",
                   {ia.plain_out, ia.out_flags});
        end else begin
          chk("out_a", {ia.plain_out, ia.out_flags}, qa.pop_front());
        end
      end
    end
    ova_d = ia.out_valid;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ib.in_valid && ib.in_ready) acc_b = cyc + 1;
      if (ib.out_valid && !ovb_d) chk("lat_b", 64'(cyc - acc_b), 64'(R));
      if (ib.out_valid && ib.out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_b_unexpected act=%h exp=none",
                   {ib.plain_out, ib.out_flags});
        end else begin
          chk("out_b", {ib.plain_out, ib.out_flags}, qb.pop_front());
        end
      end
    end
    ovb_d = ib.out_valid;
  end

  task automatic send(input bit b, input logic [N-1:0] c,
                      input logic [N-1:0] k, input exp_t e);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!(b ? ib.in_ready : ia.in_ready) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=in_ready_low exp=in_ready_high");
      return;
    end
    if (b) begin
      ib.cipher_in = c; ib.key_in = k; ib.in_valid = 1'b1;
      qb.push_back(e);
    end else begin
      ia.cipher_in = c; ia.key_in = k; ia.in_valid = 1'b1;
      qa.push_back(e);
    end
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout act=%0d exp=0", qa.size() + qb.size());
    end
  endtask

  initial begin
    logic [N-1:0] c, k, p;
    exp_t e, e2;
    int t;
    ia.in_valid = 1'b0; ia.cipher_in = '0; ia.key_in = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.cipher_in = '0; ib.key_in = '0; ib.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", {ia.in_ready, ia.out_valid, ia.plain_out, ia.out_flags},
        {1'b1, 1'b0, 32'h0, 4'h0});
    chk("rst_b", {ib.in_ready, ib.out_valid, ib.plain_out, ib.out_flags},
        {1'b1, 1'b0, 32'h0, 4'h0});
    rst_n = 1'b1;

    send(0, 32'h00000090, 32'h00000010, '{p: 32'h00004010, f: 4'b0001});
    send(0, 32'h00000000, 32'h00000000, '{p: 32'h00000000, f: 4'b0101});
    send(0, 32'h00000000, 32'h00000001, '{p: 32'hFFFFFFFE, f: 4'b1000});
    send(0, 32'h80000010, 32'h00000010, '{p: 32'h00000050, f: 4'b0001});
    drain();

    e = enc(32'h00000000, 32'h00000000, c); send(1, c, 32'h00000000, e);
    e = enc(32'hFFFFFFFF, 32'h12345678, c); send(1, c, 32'h12345678, e);
    e = enc(32'h80000000, 32'hFFFFFFFF, c); send(1, c, 32'hFFFFFFFF, e);
    for (int i = 0; i < 200; i++) begin
      p = $urandom;
      k = $urandom;
      e = enc(p, k, c);
      send(1, c, k, e);
    end
    drain();

    e  = enc(32'hCAFEBABE, 32'h01020304, c);
    @(posedge clk); #1;
    ib.out_ready = 1'b0;
    ib.cipher_in = c; ib.key_in = 32'h01020304; ib.in_valid = 1'b1;
    qb.push_back(e);
    e2 = enc(32'h0BADF00D, 32'h55AA55AA, c);
    @(posedge clk); #1;
    ib.cipher_in = c; ib.key_in = 32'h55AA55AA;
    t = 0;
    while (!ib.out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_valid", 64'(ib.out_valid), 64'(1));
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_hold", {ib.in_ready, ib.out_valid, ib.plain_out, ib.out_flags},
          {1'b0, 1'b1, e.p, e.f});
    end
    qb.push_back(e2);
    ib.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_reopen", {ib.in_ready, ib.out_valid}, 2'b10);
    @(posedge clk); #1;
    chk("bp_accept", 64'(ib.in_ready), 64'(0));
    ib.in_valid = 1'b0;
    drain();

    e = enc(32'h13572468, 32'hFEDCBA98, c);
    send(1, c, 32'hFEDCBA98, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(qb.pop_back());
    chk("rst_mid", {ib.in_ready, ib.out_valid, ib.plain_out, ib.out_flags},
        {1'b1, 1'b0, 32'h0, 4'h0});
    e = enc(32'h2468ACE0, 32'h0F0F0F0F, c);
    send(1, c, 32'h0F0F0F0F, e);
    drain();

`ifdef ARX_DEC_ABORT_EN
    e = enc(32'hDEADBEEF, 32'h00000007, c);
    send(1, c, 32'h00000007, e);
    void'(qb.pop_back());
    @(posedge clk); #1;
    abort_b = 1'b1;
    @(posedge clk); #1;
    abort_b = 1'b0;
    chk("abort_idle", {ib.in_ready, ib.out_valid}, 2'b10);
    repeat (R + 2) begin
      @(posedge clk); #1;
      chk("abort_quiet", 64'(ib.out_valid), 64'(0));
    end
    e = enc(32'h55555555, 32'hAAAAAAAA, c);
    ib.cipher_in = c; ib.key_in = 32'hAAAAAAAA; ib.in_valid = 1'b1;
    abort_b = 1'b1;
    qb.push_back(e);
    @(posedge clk); #1;
    abort_b = 1'b0;
    ib.in_valid = 1'b0;
    chk("abort_in_idle", 64'(ib.in_ready), 64'(0));
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
